// File: rtl/ppg_afe_model.sv
// ppg_afe_model
//   Synthesizable behavioural model of a pulse-oximetry analog front end.
//   It models the LED driver, photodiode, DC-compensation DAC, PGA and
//   8-bit ADC, and produces a periodic Vppg sample stream that carries a
//   synthetic heartbeat. It is the plant for closed-loop simulation and
//   FPGA bring-up of the operating-point/gain controller and the FIR chain.
//
// Ports
//   clk           in  1  system clock, all logic on the rising edge
//   rst           in  1  synchronous active-high reset
//   LED_Drive     in  4  LED current code
//   DC_Comp       in  7  DC compensation code
//   LED_RED       in  1  red LED on
//   LED_IR        in  1  IR LED on
//   PGA_Gain      in  4  gain code, gain = PGA_Gain + 1
//   Vppg          out 8  ADC sample, unsigned, midscale 128
//   sample_valid  out 1  one-cycle strobe when Vppg updates
//   led_fault     out 1  both LEDs were requested on at the last sample
//
// Build option
//   PPG_NOISE_EN  when defined, a 16-bit LFSR adds -2..+1 LSB of dither to
//                 each sample before the gain stage. Undefined by default,
//                 giving a fully deterministic output.
//
// Pipeline: the input sample is taken on the tick cycle (stage 1 load on the
// tick edge), and Vppg/sample_valid update on the following edge (stage 2).
// Inputs are ignored on all other cycles.

module ppg_afe_model #(
    parameter int SAMPLE_DIV   = 10,
    parameter int PULSE_PERIOD = 100,
    parameter int RED_DC_K     = 16,
    parameter int IR_DC_K      = 20,
    parameter int COMP_K       = 4,
    parameter int AMBIENT      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] LED_Drive,
    input  logic [6:0] DC_Comp,
    input  logic       LED_RED,
    input  logic       LED_IR,
    input  logic [3:0] PGA_Gain,
    output logic [7:0] Vppg,
    output logic       sample_valid,
    output logic       led_fault
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int PH_W  = $clog2(PULSE_PERIOD);
    localparam int RISE  = PULSE_PERIOD / 4;

    // ------------------------------------------------------------------
    // Sample divider and heartbeat phase
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div;
    logic [PH_W-1:0]  phase;
    logic             tick;

    assign tick = (div == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // phase is consumed by stage 1 on the tick cycle and advances on the
    // same edge, so a wrap only influences the following sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (tick) begin
            if (phase == PH_W'(PULSE_PERIOD - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Pulse shape: fast linear rise for the first quarter period, then a
    // slow decay at one third of the slope back to zero at the period end.
    logic [7:0] ac;

    always_comb begin
        ac = '0;
        if (phase < PH_W'(RISE)) begin
            ac = 8'(phase);
        end else begin
            ac = 8'((PULSE_PERIOD - 1 - int'(phase)) / 3);
        end
    end

    // ------------------------------------------------------------------
    // Optical front end: raw photodiode level for the current inputs
    // ------------------------------------------------------------------
    logic [11:0] dc_k;
    logic [11:0] dc_term;
    logic [11:0] ac_prod;
    logic [11:0] raw_next;

    always_comb begin
        // Red takes priority when both LEDs are requested.
        dc_k     = LED_RED ? 12'(RED_DC_K) : 12'(IR_DC_K);
        dc_term  = 12'(LED_Drive) * dc_k;
        ac_prod  = 12'(LED_Drive) * 12'(ac);
        raw_next = 12'(AMBIENT);
        if (LED_RED || LED_IR) begin
            raw_next = dc_term + (ac_prod >> 2);
        end
    end

`ifdef PPG_NOISE_EN
    // Fibonacci LFSR, taps 16,14,13,11, one step per sample.
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [1:0]  noise_q;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (tick) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`endif

    // ------------------------------------------------------------------
    // Stage 1: capture raw level and the analog settings on the tick
    // ------------------------------------------------------------------
    logic [11:0] raw_q;
    logic [6:0]  dc_q;
    logic [3:0]  gain_q;
    logic        s1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q     <= '0;
            dc_q      <= '0;
            gain_q    <= '0;
            s1_valid  <= 1'b0;
            led_fault <= 1'b0;
`ifdef PPG_NOISE_EN
            noise_q   <= '0;
`endif
        end else begin
            s1_valid <= tick;
            if (tick) begin
                raw_q     <= raw_next;
                dc_q      <= DC_Comp;
                gain_q    <= PGA_Gain;
                led_fault <= LED_RED & LED_IR;
`ifdef PPG_NOISE_EN
                noise_q   <= lfsr[1:0];
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: DC subtraction, PGA around midscale, ADC saturation
    // ------------------------------------------------------------------
    // 20-bit signed comfortably holds (1256 + 1 - 128) * 16.
    logic signed [19:0] y1;
    logic signed [19:0] v;
    logic [7:0]         v_sat;

    always_comb begin
        y1 = signed'(20'(raw_q)) - signed'(20'(dc_q) * 20'(COMP_K));
`ifdef PPG_NOISE_EN
        y1 = y1 + signed'(20'(noise_q)) - 20'sd2;
`endif
        v = 20'sd128 + (y1 - 20'sd128) * signed'(20'(gain_q) + 20'd1);
        if (v < 20'sd0) begin
            v_sat = 8'd0;
        end else if (v > 20'sd255) begin
            v_sat = 8'd255;
        end else begin
            v_sat = v[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Vppg         <= 8'd128;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= s1_valid;
            if (s1_valid) begin
                Vppg <= v_sat;
            end
        end
    end

endmodule

// File: tb/tb_ppg_afe_model.sv
// tb_ppg_afe_model
//   Directed bench for ppg_afe_model with hand-computed expected values.
//   Inputs are driven and outputs sampled on the falling clock edge.

module tb_ppg_afe_model;

    localparam int SAMPLE_DIV = 10;

    // ----------------------------------------------------------------
    // Clock / reset
    // ----------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] LED_Drive = 4'd0;
    logic [6:0] DC_Comp = 7'd0;
    logic       LED_RED = 1'b0;
    logic       LED_IR = 1'b0;
    logic [3:0] PGA_Gain = 4'd0;
    logic [7:0] Vppg;
    logic       sample_valid;
    logic       led_fault;

    always #5 clk = ~clk;

    ppg_afe_model dut (
        .clk          (clk),
        .rst          (rst),
        .LED_Drive    (LED_Drive),
        .DC_Comp      (DC_Comp),
        .LED_RED      (LED_RED),
        .LED_IR       (LED_IR),
        .PGA_Gain     (PGA_Gain),
        .Vppg         (Vppg),
        .sample_valid (sample_valid),
        .led_fault    (led_fault)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ----------------------------------------------------------------
    // Scoreboard bookkeeping
    // ----------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;
    int last_cyc = 0;
    bit have_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ----------------------------------------------------------------
    // Driver tasks
    // ----------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        have_last = 1'b0;
    endtask

    // Drive one set of inputs and return the next sample produced. Called
    // right after the previous sample, so the next tick uses these inputs.
    task automatic take_sample(input logic [3:0] drv, input logic [6:0] dc,
                               input logic red, input logic ir,
                               input logic [3:0] gain,
                               output logic [7:0] v, output logic f);
        bit got;
        got = 1'b0;
        @(negedge clk);
        LED_Drive = drv;
        DC_Comp   = dc;
        LED_RED   = red;
        LED_IR    = ir;
        PGA_Gain  = gain;
        for (int i = 0; i < 3 * SAMPLE_DIV; i++) begin
            if (sample_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("sample_timeout", 32'd0, 32'd1);
        if (have_last) check("valid_period", 32'(cyc - last_cyc), 32'(SAMPLE_DIV));
        have_last = 1'b1;
        last_cyc  = cyc;
        v = Vppg;
        f = led_fault;
    endtask

    // ----------------------------------------------------------------
    // Directed sequence
    // ----------------------------------------------------------------
    logic [7:0] v;
    logic       f;
    logic [7:0] seq [100];
    int         lat;

    initial begin
        // Reset state and first-sample latency (red, drive 10, phase 0).
        LED_RED = 1'b1; LED_Drive = 4'd10;
        do_reset();
        check("rst_vppg", 32'(Vppg), 32'd128);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_fault", 32'(led_fault), 32'd0);
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (sample_valid) begin
                lat = n;
                break;
            end
        end
        check("first_valid_edges", 32'(lat), 32'd11);
        check("red_ph0", 32'(Vppg), 32'd160);
        seq[0] = Vppg;
        have_last = 1'b1;
        last_cyc  = cyc;

        // One full heartbeat, spot-checking the hand-computed points.
        for (int p = 1; p < 100; p++) begin
            take_sample(4'd10, 7'd0, 1'b1, 1'b0, 4'd0, v, f);
            seq[p] = v;
            if (p == 24) check("red_ph24", 32'(v), 32'd220);
            if (p == 25) check("red_ph25", 32'(v), 32'd220);
            if (p == 28) check("red_ph28", 32'(v), 32'd217);
            if (p == 99) check("red_ph99", 32'(v), 32'd160);
        end
        // Second heartbeat must repeat exactly after the phase wrap.
        for (int p = 0; p < 100; p++) begin
            take_sample(4'd10, 7'd0, 1'b1, 1'b0, 4'd0, v, f);
            check($sformatf("wrap_ph%0d", p), 32'(v), 32'(seq[p]));
        end

        // DC compensation cancels the red DC at phase 0, whatever the gain.
        do_reset();
        take_sample(4'd10, 7'd8, 1'b1, 1'b0, 4'd0, v, f);
        check("dc8_g0", 32'(v), 32'd128);
        do_reset();
        take_sample(4'd10, 7'd8, 1'b1, 1'b0, 4'd7, v, f);
        check("dc8_g7", 32'(v), 32'd128);

        // Unsaturated gain: 160-40=120, 128+(120-128)*2 = 112.
        do_reset();
        take_sample(4'd10, 7'd10, 1'b1, 1'b0, 4'd1, v, f);
        check("dc10_g1", 32'(v), 32'd112);

        // High clamp at phase 24: 220-32=188, 128+60*4=368 -> 255.
        do_reset();
        for (int p = 0; p < 24; p++) take_sample(4'd10, 7'd0, 1'b1, 1'b0, 4'd0, v, f);
        take_sample(4'd10, 7'd8, 1'b1, 1'b0, 4'd3, v, f);
        check("sat_high", 32'(v), 32'd255);

        // Low clamp: 160-508 = -348 -> 0.
        do_reset();
        take_sample(4'd10, 7'd127, 1'b1, 1'b0, 4'd0, v, f);
        check("sat_low", 32'(v), 32'd0);

        // LED select: ambient for phases 0..98, both on at 99, IR at 0.
        do_reset();
        for (int p = 0; p < 99; p++) begin
            take_sample(4'd10, 7'd0, 1'b0, 1'b0, 4'd0, v, f);
            if (p == 0)  check("ambient_ph0", 32'(v), 32'd8);
            if (p == 24) check("ambient_ph24", 32'(v), 32'd8);
        end
        take_sample(4'd10, 7'd0, 1'b1, 1'b1, 4'd0, v, f);
        check("both_value", 32'(v), 32'd160);
        check("both_fault", 32'(f), 32'd1);
        take_sample(4'd10, 7'd0, 1'b0, 1'b1, 4'd0, v, f);
        check("ir_ph0", 32'(v), 32'd200);
        check("ir_fault_clr", 32'(f), 32'd0);

        // Mid-pipeline reset: sample at phase 1 is red 162, then both LEDs
        // on for the next tick and rst asserted one cycle after that tick.
        take_sample(4'd10, 7'd0, 1'b1, 1'b0, 4'd0, v, f);
        check("pre_rst_ph1", 32'(v), 32'd162);
        LED_IR = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        have_last = 1'b0;
        check("midrst_vppg", 32'(Vppg), 32'd128);
        check("midrst_valid", 32'(sample_valid), 32'd0);
        check("midrst_fault", 32'(led_fault), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_valid", 32'(sample_valid), 32'd0);
        end
        take_sample(4'd10, 7'd0, 1'b1, 1'b0, 4'd0, v, f);
        check("post_rst_ph0", 32'(v), 32'd160);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ppg_afe_model.md
# ppg_afe_model

- Synthesizable behavioural model of the pulse-oximetry analog front end: LED driver, photodiode, DC-compensation DAC, PGA and 8-bit ADC.
- Sits on the other side of the LED/DC/gain control interface from the operating-point/gain controller. It consumes `LED_Drive`, `DC_Comp`, `LED_RED`, `LED_IR` and `PGA_Gain`, and returns a periodic `Vppg` sample stream with a synthetic heartbeat.
- Used for closed-loop simulation and FPGA bring-up of the controller and FIR filter chain.

## Interface
- `SAMPLE_DIV`, 10: clk cycles per ADC sample (≥3).
- `PULSE_PERIOD`, 100: samples per heartbeat (≥8).
- `RED_DC_K`, 16: red DC photocurrent per LED_Drive step.
- `IR_DC_K`, 20: IR DC photocurrent per LED_Drive step.
- `COMP_K`, 4: DC subtracted per DC_Comp step.
- `AMBIENT`, 8: raw level with both LEDs off.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `LED_Drive` in 4: LED current code.
- `DC_Comp` in 7: DC compensation code.
- `LED_RED` in 1: red LED on.
- `LED_IR` in 1: IR LED on.
- `PGA_Gain` in 4: gain code; gain = PGA_Gain+1.
- `Vppg` out 8: ADC sample, unsigned, midscale 128.
- `sample_valid` out 1: one-cycle strobe when Vppg updates.
- `led_fault` out 1: both LEDs requested on at the last sample.

## Operation
Sample divider:
- `div` counts 0..SAMPLE_DIV-1 and wraps.
- `tick` = (div == SAMPLE_DIV-1).

Heartbeat phase:
- `phase` counts 0..PULSE_PERIOD-1 and advances on each tick, after being used. It wraps to 0.
- RISE = PULSE_PERIOD/4 (integer division).
- ac = phase when phase < RISE; otherwise ac = (PULSE_PERIOD-1-phase)/3. Unsigned 8 bits.

Stage 1 (on tick, inputs sampled this cycle). raw is 12-bit unsigned:
- LED_RED=1: raw = LED_Drive·RED_DC_K + ((LED_Drive·ac)>>2).
- LED_RED=0, LED_IR=1: same formula with IR_DC_K.
- Both 0: raw = AMBIENT.
- Both 1: red formula is used and led_fault is set. led_fault is cleared at the next stage-1 load with at most one LED on.

Stage 2 (cycle after tick), signed arithmetic at ≥18 bits, no intermediate overflow:
- y1 = raw − DC_Comp·COMP_K, using DC_Comp as sampled in stage 1.
- v = 128 + (y1 − 128)·(PGA_Gain+1).
- Vppg = saturate(v, 0, 255).
- sample_valid = 1 for this cycle only.

Other behaviour:
- No state machine beyond the counters and the two-stage pipeline.
- Inputs are only observed on tick cycles, so changes between ticks have no effect.

## Timing
Reset values:
- `div`=0, `phase`=0.
- `Vppg`=128, `sample_valid`=0, `led_fault`=0.
- Pipeline registers cleared.

Cadence and latency:
- First tick is the SAMPLE_DIV-th cycle after rst deasserts (div=SAMPLE_DIV-1).
- Vppg/sample_valid are visible two rising edges after the tick edge.
- Latency from input sampling to output is 2 clk.
- sample_valid period is exactly SAMPLE_DIV cycles.

Corner cases:
- rst asserted mid-pipeline: the in-flight sample is discarded, no sample_valid is issued, and all values return to reset state on the next edge.
- `phase` wrap and output update may coincide. The wrap affects only the next sample.

## Configuration
- `PPG_NOISE_EN` defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, reset to seed, advances once per tick.
  - Stage 2 uses y1' = y1 + {lfsr[1:0]} − 2 (range −2..+1) before gain.
- Undefined: no LFSR, output fully deterministic.
- All test plan values below assume the macro is undefined.

## Test plan
- Reset: hold rst 3 cycles, release → Vppg=128, sample_valid=0, led_fault=0. First sample_valid occurs 2 edges after the tick at div=9; pulses then recur every 10 cycles.
- Red, LED_Drive=10, DC_Comp=0, PGA_Gain=0:
  - sample at phase 0 → Vppg=160.
  - sample at phase 24 → raw=220 → Vppg=220.
- DC and gain, LED_Drive=10:
  - DC_Comp=8, phase 0 → Vppg=128 for any PGA_Gain.
  - DC_Comp=8, phase 24, PGA_Gain=3 → 128+60·4=368 → Vppg=255 (saturate).
- Low clamp: DC_Comp=127, LED_Drive=10, phase 0, PGA_Gain=0 → y1=−348 → Vppg=0.
- LED select:
  - LED_RED=LED_IR=0 → Vppg=8 at DC_Comp=0, gain 0.
  - Both 1 → led_fault=1 and red value.
  - Then LED_IR only, LED_Drive=10, phase 0 → Vppg=200, led_fault=0.
- Wrap and mid-operation reset:
  - 100 consecutive samples → phase returns to 0 and Vppg sequence repeats exactly.
  - rst pulsed one cycle after a tick → no sample_valid for that tick, Vppg=128.
